// File: rtl/dma_axi_if.sv
// AXI4 master-side bus bundle for the DMA burst engine: AW/W/B/AR/R channels.
interface dma_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     M_AWID;
  logic [ADDR_W-1:0]   M_AWAddr;
  logic [3:0]          M_AWLen;
  logic [2:0]          M_AWSize;
  logic [1:0]          M_AWBurst;
  logic                M_AWValid, M_AWReady;
  logic [DATA_W-1:0]   M_WData;
  logic [DATA_W/8-1:0] M_WStrb;
  logic                M_WLast, M_WValid, M_WReady;
  logic [ID_W-1:0]     M_BID;
  logic [1:0]          M_BResp;
  logic                M_BValid, M_BReady;
  logic [ID_W-1:0]     M_ARID;
  logic [ADDR_W-1:0]   M_ARAddr;
  logic [3:0]          M_ARLen;
  logic [2:0]          M_ARSize;
  logic [1:0]          M_ARBurst;
  logic                M_ARValid, M_ARReady;
  logic [ID_W-1:0]     M_RID;
  logic [DATA_W-1:0]   M_RData;
  logic [1:0]          M_RResp;
  logic                M_RLast, M_RValid, M_RReady;

  modport master (
    output M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid, input M_AWReady,
    output M_WData, M_WStrb, M_WLast, M_WValid, input M_WReady,
    input M_BID, M_BResp, M_BValid, output M_BReady,
    output M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid, input M_ARReady,
    input M_RID, M_RData, M_RResp, M_RLast, M_RValid, output M_RReady
  );

  modport slave (
    input M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid, output M_AWReady,
    input M_WData, M_WStrb, M_WLast, M_WValid, output M_WReady,
    output M_BID, M_BResp, M_BValid, input M_BReady,
    input M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid, output M_ARReady,
    output M_RID, M_RData, M_RResp, M_RLast, M_RValid, input M_RReady
  );
endinterface

// File: rtl/dma_burst_engine.sv
// Memory-to-memory DMA: copies DMALEN words as read-then-write INCR bursts of up to MAX_BURST beats.
// Optional macro DMA_ERR_ABORT_EN adds DMA_error and aborts on non-OKAY R/B responses.
module dma_burst_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DMAEN,
  input  logic [ADDR_W-1:0] DMASRC,
  input  logic [ADDR_W-1:0] DMADST,
  input  logic [LEN_W-1:0]  DMALEN,
  input  logic              DMA_INTCLR,
  output logic              DMA_interrupt,
  output logic              DMA_busy,
`ifdef DMA_ERR_ABORT_EN
  output logic              DMA_error,
`endif
  dma_axi_if.master         m
);
  localparam int BW = $clog2(DATA_W/8);
  localparam int IW = $clog2(MAX_BURST);
  localparam int CW = IW + 1;

  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RADDR = 3'd2, RDATA = 3'd3,
                         WADDR = 3'd4, WDATA = 3'd5, WRESP = 3'd6, DONE = 3'd7;

  logic [2:0]        state;
  logic              en_q, intr;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  remain;
  logic [CW-1:0]     blen, rcnt, wcnt;
  logic [IW-1:0]     wnext;
  logic [DATA_W-1:0] buf_q [MAX_BURST];
  logic [DATA_W-1:0] wdata;
  logic              last_burst, wlast, rd_abort, wr_abort, enter_done;

  function automatic logic [CW-1:0] clip(input logic [LEN_W-1:0] n);
    return (n >= LEN_W'(MAX_BURST)) ? CW'(MAX_BURST) : CW'(n);
  endfunction

  assign wnext      = wcnt[IW-1:0] + 1'b1;
  assign wlast      = (state == WDATA) && (wcnt == blen - 1'b1);
  assign last_burst = (remain == LEN_W'(blen));

`ifdef DMA_ERR_ABORT_EN
  logic err;
  assign rd_abort  = err || (m.M_RResp != 2'b00);
  assign wr_abort  = (m.M_BResp != 2'b00);
  assign DMA_error = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (state == IDLE && DMAEN && !en_q) err <= 1'b0;
    else if ((state == RDATA && m.M_RValid && m.M_RResp != 2'b00) ||
             (state == WRESP && m.M_BValid && m.M_BResp != 2'b00)) err <= 1'b1;
    else if (DMA_INTCLR) err <= 1'b0;
  end
`else
  assign rd_abort = 1'b0;
  assign wr_abort = 1'b0;
`endif

  // Response IDs are never checked; responses matter only with the abort option.
  logic unused_in;
  assign unused_in = ^{m.M_BID, m.M_RID, m.M_BResp, m.M_RResp};

  assign enter_done = (state == LOAD && DMALEN == '0) ||
                      (state == RDATA && m.M_RValid && m.M_RLast && rd_abort) ||
                      (state == WRESP && m.M_BValid && (last_burst || wr_abort));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      en_q   <= 1'b0;
      intr   <= 1'b0;
      src    <= '0;
      dst    <= '0;
      remain <= '0;
      blen   <= '0;
      rcnt   <= '0;
      wcnt   <= '0;
      wdata  <= '0;
      for (int i = 0; i < MAX_BURST; i++) buf_q[i] <= '0;
    end else begin
      en_q <= DMAEN;
      if (enter_done)      intr <= 1'b1;
      else if (DMA_INTCLR) intr <= 1'b0;
      case (state)
        IDLE:  if (DMAEN && !en_q) state <= LOAD;
        LOAD: begin
          src    <= DMASRC;
          dst    <= DMADST;
          remain <= DMALEN;
          blen   <= clip(DMALEN);
          rcnt   <= '0;
          wcnt   <= '0;
          state  <= enter_done ? DONE : RADDR;
        end
        RADDR: if (m.M_ARReady) state <= RDATA;
        RDATA: if (m.M_RValid) begin
          // Excess beats from a misbehaving slave are dropped instead of wrapping the buffer.
          if (rcnt < CW'(MAX_BURST)) buf_q[rcnt[IW-1:0]] <= m.M_RData;
          rcnt <= rcnt + 1'b1;
          if (m.M_RLast) begin
            rcnt  <= '0;
            state <= enter_done ? DONE : WADDR;
          end
        end
        WADDR: if (m.M_AWReady) begin
          wdata <= buf_q[0];
          state <= WDATA;
        end
        WDATA: if (m.M_WReady) begin
          wcnt  <= wcnt + 1'b1;
          wdata <= buf_q[wnext];
          if (wlast) begin
            wcnt  <= '0;
            state <= WRESP;
          end
        end
        WRESP: if (m.M_BValid) begin
          src    <= src + (ADDR_W'(blen) << BW);
          dst    <= dst + (ADDR_W'(blen) << BW);
          remain <= remain - LEN_W'(blen);
          blen   <= clip(remain - LEN_W'(blen));
          state  <= enter_done ? DONE : RADDR;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign DMA_interrupt = intr;
  assign DMA_busy      = (state != IDLE) && (state != DONE);

  assign m.M_ARID    = '0;
  assign m.M_ARAddr  = src;
  assign m.M_ARLen   = 4'(blen - 1'b1);
  assign m.M_ARSize  = 3'(BW);
  assign m.M_ARBurst = 2'b01;
  assign m.M_ARValid = (state == RADDR);
  assign m.M_RReady  = (state == RDATA);

  assign m.M_AWID    = '0;
  assign m.M_AWAddr  = dst;
  assign m.M_AWLen   = 4'(blen - 1'b1);
  assign m.M_AWSize  = 3'(BW);
  assign m.M_AWBurst = 2'b01;
  assign m.M_AWValid = (state == WADDR);

  assign m.M_WData   = wdata;
  assign m.M_WStrb   = '1;
  assign m.M_WLast   = wlast;
  assign m.M_WValid  = (state == WDATA);
  assign m.M_BReady  = (state == WRESP);
endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed + randomized bench for dma_burst_engine against an AXI slave memory model.
module tb_dma_burst_engine;
  localparam int AW = 32, DW = 32, IDW = 4, LW = 32, MB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          DMAEN = 1'b0, DMA_INTCLR = 1'b0;
  logic [AW-1:0] DMASRC = '0, DMADST = '0;
  logic [LW-1:0] DMALEN = '0;
  logic          DMA_interrupt, DMA_busy;
`ifdef DMA_ERR_ABORT_EN
  logic          DMA_error;
`endif

  dma_axi_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IDW)) bus ();

  dma_burst_engine #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IDW), .LEN_W(LW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
    .DMA_INTCLR(DMA_INTCLR), .DMA_interrupt(DMA_interrupt), .DMA_busy(DMA_busy),
`ifdef DMA_ERR_ABORT_EN
    .DMA_error(DMA_error),
`endif
    .m(bus)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave memory model ----------------
  logic [31:0] mem [0:1023];
  function automatic logic [9:0] idx(input logic [31:0] a);
    return a[11:2];
  endfunction

  int stall_max = 0, rgap_max = 0, inj_burst = 0;
  int n_ar, n_aw, n_b, n_w, n_irq, exp_nar, exp_naw;
  logic [31:0] exp_ar_addr[$], exp_aw_addr[$];
  int          exp_ar_len[$], exp_aw_len[$];
  logic [31:0] src_base, dst_base;

  logic        ar_armed, aw_armed, w_armed, rd_active, b_pend, irq_q;
  int          ar_cnt, aw_cnt, w_cnt, rgap, b_cnt, rd_left, wr_len, wr_idx;
  logic [31:0] rd_addr, wr_addr;
  logic        ar_stall, aw_stall, w_stall;
  logic [63:0] ar_snap, aw_snap, w_snap;

  task automatic slave_clear();
    ar_armed = 0; aw_armed = 0; w_armed = 0; rd_active = 0; b_pend = 0; irq_q = 0;
    ar_stall = 0; aw_stall = 0; w_stall = 0;
    bus.M_ARReady = 0; bus.M_AWReady = 0; bus.M_WReady = 0;
    bus.M_BValid = 0; bus.M_BResp = 0; bus.M_BID = '0;
    bus.M_RValid = 0; bus.M_RData = '0; bus.M_RResp = 0; bus.M_RLast = 0; bus.M_RID = '0;
  endtask

  // All slave activity happens on the falling edge; a handshake decided here completes on the next rising edge.
  initial begin : slave
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin slave_clear(); continue; end
      if (DMA_interrupt && !irq_q) n_irq++;
      irq_q = DMA_interrupt;
      if (ar_stall) chk("ar_stable", {bus.M_ARValid, bus.M_ARLen, bus.M_ARAddr}, ar_snap);
      if (aw_stall) chk("aw_stable", {bus.M_AWValid, bus.M_AWLen, bus.M_AWAddr}, aw_snap);
      if (w_stall)  chk("w_stable", {bus.M_WValid, bus.M_WLast, bus.M_WData}, w_snap);

      bus.M_RValid = 0; bus.M_RLast = 0; bus.M_RResp = 0;
      if (rd_active) begin
        if (rgap > 0) rgap--;
        else begin
          bus.M_RValid = 1;
          bus.M_RData  = mem[idx(rd_addr)];
          bus.M_RLast  = (rd_left == 1);
          bus.M_RResp  = (inj_burst != 0 && n_ar == inj_burst) ? 2'b10 : 2'b00;
          if (bus.M_RReady) begin
            rd_addr += 4; rd_left--;
            if (rd_left == 0) rd_active = 0;
            rgap = $urandom_range(0, rgap_max);
          end
        end
      end

      bus.M_BValid = 0;
      if (b_pend) begin
        if (b_cnt > 0) b_cnt--;
        else begin
          bus.M_BValid = 1;
          if (bus.M_BReady) begin b_pend = 0; n_b++; end
        end
      end

      if (bus.M_ARValid && !ar_armed) begin ar_armed = 1; ar_cnt = $urandom_range(0, stall_max); end
      bus.M_ARReady = ar_armed && ar_cnt == 0;
      if (ar_armed && ar_cnt > 0) ar_cnt--;
      ar_stall = bus.M_ARValid && !bus.M_ARReady;
      ar_snap  = {27'd0, bus.M_ARValid, bus.M_ARLen, bus.M_ARAddr};
      if (bus.M_ARValid && bus.M_ARReady) begin
        ar_armed = 0; n_ar++;
        chk("ar_expected", exp_ar_addr.size() != 0, 1);
        if (exp_ar_addr.size() != 0) begin
          chk("ar_addr", bus.M_ARAddr, exp_ar_addr.pop_front());
          chk("ar_len", bus.M_ARLen, exp_ar_len.pop_front());
        end
        chk("ar_attr", {bus.M_ARID, bus.M_ARSize, bus.M_ARBurst}, {4'd0, 3'd2, 2'b01});
        rd_active = 1; rd_addr = bus.M_ARAddr; rd_left = bus.M_ARLen + 1;
        rgap = $urandom_range(0, rgap_max);
      end

      if (bus.M_WValid && !w_armed) begin w_armed = 1; w_cnt = $urandom_range(0, stall_max); end
      bus.M_WReady = w_armed && w_cnt == 0;
      if (w_armed && w_cnt > 0) w_cnt--;
      w_stall = bus.M_WValid && !bus.M_WReady;
      w_snap  = {bus.M_WValid, bus.M_WLast, bus.M_WData};
      if (bus.M_WValid && bus.M_WReady) begin
        w_armed = 0; n_w++;
        chk("w_data", bus.M_WData, mem[idx(src_base + (wr_addr - dst_base) + 32'(4 * wr_idx))]);
        chk("w_last", bus.M_WLast, wr_idx == wr_len);
        chk("w_strb", bus.M_WStrb, 4'hF);
        mem[idx(wr_addr + 32'(4 * wr_idx))] = bus.M_WData;
        if (bus.M_WLast) begin b_pend = 1; b_cnt = $urandom_range(0, stall_max); end
        wr_idx++;
      end

      if (bus.M_AWValid && !aw_armed) begin aw_armed = 1; aw_cnt = $urandom_range(0, stall_max); end
      bus.M_AWReady = aw_armed && aw_cnt == 0;
      if (aw_armed && aw_cnt > 0) aw_cnt--;
      aw_stall = bus.M_AWValid && !bus.M_AWReady;
      aw_snap  = {27'd0, bus.M_AWValid, bus.M_AWLen, bus.M_AWAddr};
      if (bus.M_AWValid && bus.M_AWReady) begin
        aw_armed = 0; n_aw++;
        chk("aw_expected", exp_aw_addr.size() != 0, 1);
        if (exp_aw_addr.size() != 0) begin
          chk("aw_addr", bus.M_AWAddr, exp_aw_addr.pop_front());
          chk("aw_len", bus.M_AWLen, exp_aw_len.pop_front());
        end
        chk("aw_attr", {bus.M_AWID, bus.M_AWSize, bus.M_AWBurst}, {4'd0, 3'd2, 2'b01});
        wr_addr = bus.M_AWAddr; wr_len = bus.M_AWLen; wr_idx = 0;
      end
    end
  end

  // ---------------- reference plan and directed steps ----------------
  // Plans the burst list from the word count; err_b>0 means burst err_b is read but never written.
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int err_b);
    int rem, l, k;
    logic [31:0] off;
    src_base = s; dst_base = d;
    for (int i = 0; i < n; i++) begin
      mem[idx(s + 32'(4 * i))] = $urandom;
      mem[idx(d + 32'(4 * i))] = 32'hDEAD_0000 + 32'(i);
    end
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
    rem = n; off = 0; k = 1;
    while (rem > 0) begin
      l = (rem > MB) ? MB : rem;
      exp_ar_addr.push_back(s + off); exp_ar_len.push_back(l - 1);
      if (err_b != 0 && k == err_b) break;
      exp_aw_addr.push_back(d + off); exp_aw_len.push_back(l - 1);
      rem -= l; off += 32'(4 * l); k++;
    end
    exp_nar = exp_ar_addr.size(); exp_naw = exp_aw_addr.size();
    n_ar = 0; n_aw = 0; n_b = 0; n_w = 0; n_irq = 0;
    DMASRC = s; DMADST = d; DMALEN = n;
    @(negedge clk); DMAEN = 1;
    @(negedge clk); DMAEN = 0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!DMA_interrupt && cyc < 5000) begin @(negedge clk); cyc++; end
    chk({tag, "_irq"}, DMA_interrupt, 1);
  endtask

  task automatic finish_copy(input string tag, input int nwords);
    repeat (2) @(negedge clk);
    chk({tag, "_nar"}, n_ar, exp_nar);
    chk({tag, "_naw"}, n_aw, exp_naw);
    chk({tag, "_nb"}, n_b, exp_naw);
    chk({tag, "_nw"}, n_w, nwords);
    chk({tag, "_irq_rises"}, n_irq, 1);
    for (int i = 0; i < nwords; i++)
      chk({tag, "_copy"}, mem[idx(dst_base + 32'(4 * i))], mem[idx(src_base + 32'(4 * i))]);
    DMA_INTCLR = 1; @(negedge clk); DMA_INTCLR = 0; @(negedge clk);
    chk({tag, "_irq_clr"}, DMA_interrupt, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus.M_ARValid, bus.M_AWValid, bus.M_WValid, bus.M_BReady, bus.M_RReady,
                     DMA_interrupt, DMA_busy}, 0);
    chk("rst_wdata", bus.M_WData, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    stall_max = 0; rgap_max = 0;
    start_copy(32'h100, 32'h800, 5, 0);
    @(negedge clk);
    chk("ar_latency", bus.M_ARValid, 1);
    chk("busy_on", DMA_busy, 1);
    wait_done("len5");
    finish_copy("len5", 5);

    start_copy(32'h100, 32'h800, 37, 0);
    wait_done("len37");
    finish_copy("len37", 37);

    start_copy(32'h100, 32'h800, 0, 0);
    cyc = 0;
    while (!DMA_interrupt && cyc < 10) begin @(negedge clk); cyc++; end
    chk("len0_irq", DMA_interrupt, 1);
    chk("len0_latency", cyc <= 2, 1);
    finish_copy("len0", 0);

    stall_max = 7; rgap_max = 7;
    start_copy(32'h200, 32'hA00, 20, 0);
    repeat (15) @(negedge clk);
    chk("busy_mid", DMA_busy, 1);
    DMAEN = 1; @(negedge clk); DMAEN = 0;
    wait_done("rand20");
    finish_copy("rand20", 20);
    repeat (10) @(negedge clk);
    chk("no_restart", n_ar, exp_nar);
    chk("idle_busy", DMA_busy, 0);

    stall_max = 3; rgap_max = 2;
    start_copy(32'h100, 32'h800, 37, 0);
    cyc = 0;
    while (!(n_aw == 2 && bus.M_WValid) && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("reach_wdata2", n_aw == 2 && bus.M_WValid, 1);
    #2 rst = 1;
    #1;
    chk("rst_mid_ctrl", {bus.M_ARValid, bus.M_AWValid, bus.M_WValid, bus.M_BReady, bus.M_RReady,
                         DMA_interrupt, DMA_busy}, 0);
    chk("rst_mid_wdata", bus.M_WData, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    start_copy(32'h300, 32'hC00, 20, 0);
    wait_done("post_rst");
    finish_copy("post_rst", 20);

`ifdef DMA_ERR_ABORT_EN
    stall_max = 0; rgap_max = 0; inj_burst = 2;
    start_copy(32'h100, 32'h800, 32, 2);
    wait_done("err");
    repeat (2) @(negedge clk);
    chk("err_nar", n_ar, 2);
    chk("err_naw", n_aw, 1);
    chk("err_flag", DMA_error, 1);
    chk("err_irq", DMA_interrupt, 1);
    for (int i = 0; i < 16; i++)
      chk("err_copy", mem[idx(32'h800 + 32'(4 * i))], mem[idx(32'h100 + 32'(4 * i))]);
    DMA_INTCLR = 1; @(negedge clk); DMA_INTCLR = 0; @(negedge clk);
    chk("err_clr", {DMA_error, DMA_interrupt}, 0);
    inj_burst = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dma_burst_engine.md
Name: dma_burst_engine

Overview:
- Parametrised memory-to-memory DMA engine and the next generation of the single-burst DMA. It sits behind the CPU-programmed DMA register slave and drives one AXI master port.
- It copies DMALEN data words from DMASRC to DMADST as a sequence of INCR bursts. Each burst is at most MAX_BURST beats; the final burst is shortened to fit.
- Read data is staged in an internal MAX_BURST-deep buffer before each write burst. A level interrupt signals completion and stays up until the CPU clears it.

Parameters:
- ADDR_W, 32, AXI address width and width of DMASRC/DMADST.
- DATA_W, 32, AXI data width; must be 32 or 64.
- ID_W, 4, AXI ID width; all IDs driven as 0.
- LEN_W, 32, width of DMALEN (word count).
- MAX_BURST, 16, maximum beats per burst; power of 2, from 2 to 16.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- DMAEN  in  1  start request; a rising edge seen in IDLE starts a transfer
- DMASRC  in  ADDR_W  source byte address, DATA_W/8 aligned
- DMADST  in  ADDR_W  destination byte address, DATA_W/8 aligned
- DMALEN  in  LEN_W  number of DATA_W words to copy
- DMA_INTCLR  in  1  one-cycle pulse that clears DMA_interrupt
- DMA_interrupt  out  1  transfer complete (level)
- DMA_busy  out  1  high in any state other than IDLE and DONE
- M_AW*: M_AWID ID_W, M_AWAddr ADDR_W, M_AWLen 4, M_AWSize 3, M_AWBurst 2, M_AWValid out, M_AWReady in
- M_W*: M_WData DATA_W, M_WStrb DATA_W/8, M_WLast, M_WValid out, M_WReady in
- M_B*: M_BID ID_W in, M_BResp 2 in, M_BValid in, M_BReady out
- M_AR*: M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid out, M_ARReady in
- M_R*: M_RID, M_RData, M_RResp, M_RLast, M_RValid in, M_RReady out

Behaviour:
- Reset (asynchronous, immediate, also when asserted mid-transfer): state IDLE; every Valid, Ready, interrupt and busy output 0; M_WData 0; buffer and counters 0. No AXI transaction is completed after reset.
- States: IDLE, LOAD, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
- IDLE: a DMAEN rising edge (DMAEN=1 now, 0 in the previous cycle) moves to LOAD. DMAEN is ignored in every other state.
- LOAD: latch src, dst and remain=DMALEN.
  - remain==0: go to DONE with no AXI traffic.
  - otherwise: set blen=min(remain,MAX_BURST) and go to RADDR.
- RADDR: M_ARValid=1. M_ARAddr, M_ARLen=blen-1, M_ARSize=log2(DATA_W/8) and M_ARBurst=2'b01 stay stable until M_ARReady. On the handshake go to RDATA.
- RDATA: M_RReady=1. Each beat writes buffer[rcnt] and increments rcnt. The beat with M_RLast goes to WADDR. An M_RLast arriving before blen beats also ends the burst.
- WADDR: same rules as RADDR, using dst and M_AW*.
- WDATA: M_WValid=1 and M_WData=buffer[wcnt], registered so data is valid in the same cycle as Valid. M_WStrb is all ones. M_WLast=1 when wcnt==blen-1. wcnt advances only on M_WValid&&M_WReady. The last handshake goes to WRESP.
- WRESP: M_BReady=1. On the B handshake:
  - src += blen*DATA_W/8, dst += blen*DATA_W/8, remain -= blen.
  - remain==0 goes to DONE; otherwise recompute blen and go to RADDR.
- DONE: set DMA_interrupt, return to IDLE the next cycle.
- DMA_interrupt: set on entering DONE, cleared by DMA_INTCLR. If set and clear fall in the same cycle, set wins.
- Latencies:
  - Minimum AR valid is 2 cycles after the DMAEN edge.
  - Minimum turnaround from RLast to AWValid is 1 cycle.
  - Minimum turnaround from B handshake to the next ARValid is 1 cycle.
- Address arithmetic wraps at 2^ADDR_W. Bursts that cross a 4 KB boundary are not split; software guarantees alignment.
- Only one burst is outstanding at a time. Read and write never overlap.
- RResp and BResp are ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: DMA_ERR_ABORT_EN.
- Defined:
  - Adds output DMA_error (1 bit, reset 0).
  - Any R beat with M_RResp!=2'b00, or a B response with M_BResp!=2'b00, sets DMA_error.
  - A read error completes the current R burst (draining to RLast) and then goes to DONE without issuing the write. A write error goes to DONE after the B handshake.
  - DMA_error is cleared by DMA_INTCLR and by the next DMAEN start.
- Undefined: the port does not exist and responses are ignored.

Test Plan:
- DMALEN=5, MAX_BURST=16, zero-wait slave:
  - One AR with ARLen=4 and one AW with AWLen=4.
  - Five W beats with WLast on the 5th; destination equals source.
  - DMA_interrupt rises once.
- DMALEN=37, MAX_BURST=16: burst lengths 16,16,5. Addresses step by 64 bytes (DATA_W=32). Three B handshakes, then the interrupt.
- DMALEN=0: no AR or AW is issued. DMA_interrupt=1 within 3 cycles of the DMAEN edge.
- Random AR/AW/W/B ready stalls of 0–7 cycles and RValid gaps, DMALEN=20:
  - All Valid and payload signals stay stable while stalled.
  - Data copies correctly.
  - DMAEN pulsed mid-transfer is ignored.
- rst asserted during WDATA of the second burst: all outputs are 0 in the same cycle. After release, a new DMAEN edge performs a full correct copy.
- DMA_ERR_ABORT_EN, DMALEN=32, slave returns RResp=2'b10 on burst 2:
  - Burst 2 has no AW.
  - DMA_error=1 and DMA_interrupt=1.
  - DMA_INTCLR clears both.
